maze_grid_tracker: RTL

Parametrised maze-state memory and pixel-colour lookup between the robot radio link and the VGA driver. It replaces the fixed 4x5 per-cell register grid with an ROWS x COLS cell store. Position packets arrive over a valid/ready handshake. An internal sweep FSM clears the store after reset or on demand. A 2-stage pipeline turns VGA pixel coordinates into an 8-bit RGB332 colour.

---
 rtl/maze_pkg.sv | 57 +++++
 rtl/maze_cell_ram.sv | 48 ++++
 rtl/maze_grid_tracker.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types, colour constants and helpers for the maze grid tracker.
// Optional treasure storage is enabled by defining GRID_TREASURE_EN.
package maze_pkg;

    typedef enum logic [1:0] {
        CELL_UNVISITED = 2'd0,
        CELL_VISITED   = 2'd1,
        CELL_CURRENT   = 2'd2,
        CELL_RESERVED  = 2'd3
    } cell_state_t;

    typedef enum logic [1:0] {
        TRS_NONE = 2'd0,
        TRS_7K   = 2'd1,
        TRS_12K  = 2'd2,
        TRS_17K  = 2'd3
    } treasure_t;

    typedef enum logic [1:0] {
        ST_SWEEP  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPDATE = 2'd2
    } fsm_state_t;

    // RGB332 palette
    localparam logic [7:0] RGB_BLACK  = 8'h00;
    localparam logic [7:0] RGB_BLUE   = 8'h03;
    localparam logic [7:0] RGB_GREEN  = 8'h1C;
    localparam logic [7:0] RGB_RED    = 8'hE0;
    localparam logic [7:0] RGB_PURPLE = 8'b101_000_11;
    localparam logic [7:0] RGB_YELLOW = 8'b111_111_00;
    localparam logic [7:0] RGB_WHITE  = 8'hFF;

    // Index width that stays at least one bit for single-entry ranges
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Display colour of a cell; a nonzero treasure code overrides the state colour
    function automatic logic [7:0] cell_colour(input logic [1:0] state, input logic [1:0] trs);
        logic [7:0] c;
        case (state)
            CELL_UNVISITED: c = RGB_BLACK;
            CELL_VISITED:   c = RGB_BLUE;
            CELL_CURRENT:   c = RGB_GREEN;
            default:        c = RGB_RED;
        endcase
        case (trs)
            TRS_7K:  c = RGB_PURPLE;
            TRS_12K: c = RGB_YELLOW;
            TRS_17K: c = RGB_WHITE;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/maze_cell_ram.sv
// 1-write/1-read synchronous cell store; a same-cycle read of a written cell
// returns the old contents. Treasure plane exists only with GRID_TREASURE_EN.
module maze_cell_ram #(
    parameter int unsigned DEPTH = 20,
    parameter int unsigned AW    = 5
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [1:0]    wr_state_i,
`ifdef GRID_TREASURE_EN
    input  logic          trs_wr_en_i,
    input  logic [1:0]    wr_trs_i,
    output logic [1:0]    rd_trs_o,
`endif
    input  logic [AW-1:0] rd_addr_i,
    output logic [1:0]    rd_state_o
);

    logic [1:0] state_mem [DEPTH];
    logic [1:0] rd_state_q;

    // Cell-state plane: write port plus registered read port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            state_mem[wr_addr_i] <= wr_state_i;
        end
        rd_state_q <= state_mem[rd_addr_i];
    end

    assign rd_state_o = rd_state_q;

`ifdef GRID_TREASURE_EN
    logic [1:0] trs_mem [DEPTH];
    logic [1:0] rd_trs_q;

    // Treasure plane, written independently of the state plane
    always_ff @(posedge clk_i) begin
        if (trs_wr_en_i) begin
            trs_mem[wr_addr_i] <= wr_trs_i;
        end
        rd_trs_q <= trs_mem[rd_addr_i];
    end

    assign rd_trs_o = rd_trs_q;
`endif

endmodule

// File: rtl/maze_grid_tracker.sv
// Maze-state tracker: packet-driven cell updates, clear sweep and a 2-stage
// VGA pixel-to-colour pipeline. Define GRID_TREASURE_EN for treasure storage.
module maze_grid_tracker
    import maze_pkg::*;
#(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 5,
    parameter int unsigned CELL_PX = 50,
    parameter int unsigned RW      = idx_width(ROWS),
    parameter int unsigned CW      = idx_width(COLS)
) (
    input  logic                             CLOCK,
    input  logic                             RESET_N,
    input  logic                             CLEAR,
    input  logic                             PKT_VALID,
    output logic                             PKT_READY,
    input  logic [RW-1:0]                    PKT_ROW,
    input  logic [CW-1:0]                    PKT_COL,
`ifdef GRID_TREASURE_EN
    input  logic [1:0]                       PKT_TREASURE,
`endif
    output logic                             PKT_ERR,
    input  logic [9:0]                       PIXEL_X,
    input  logic [9:0]                       PIXEL_Y,
    output logic [7:0]                       PIXEL_COLOR,
    output logic                             CUR_VALID,
    output logic [RW-1:0]                    CUR_ROW,
    output logic [CW-1:0]                    CUR_COL,
    output logic [$clog2(ROWS*COLS+1)-1:0]   VISITED_COUNT,
    output logic                             DONE
);

    localparam int unsigned NCELLS = ROWS * COLS;
    localparam int unsigned AW     = idx_width(NCELLS);
    localparam int unsigned CNT_W  = $clog2(NCELLS + 1);
    localparam int unsigned GRID_W = COLS * CELL_PX;
    localparam int unsigned GRID_H = ROWS * CELL_PX;

    function automatic logic [AW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(32'(r) * COLS + 32'(c));
    endfunction

    fsm_state_t        state_q, state_d;
    logic              upd_phase_q, upd_phase_d;
    logic [AW-1:0]     sweep_idx_q, sweep_idx_d;

    logic [RW-1:0]     new_row_q, new_row_d;
    logic [CW-1:0]     new_col_q, new_col_d;
    logic              cur_valid_q, cur_valid_d;
    logic [RW-1:0]     cur_row_q, cur_row_d;
    logic [CW-1:0]     cur_col_q, cur_col_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NCELLS-1:0] occupied_q, occupied_d;
    logic              pkt_ready_q, pkt_ready_d;
    logic              pkt_err_q, pkt_err_d;
    logic              done_q, done_d;

    logic              accept_c;
    logic              in_range_c;
    logic [AW-1:0]     new_idx_c;
    logic [AW-1:0]     cur_idx_c;

    logic              ram_we_c;
    logic [AW-1:0]     ram_waddr_c;
    logic [1:0]        ram_wstate_c;
    logic [1:0]        rd_state;
    logic [1:0]        rd_trs_c;

    logic [CW-1:0]     px_col_c;
    logic [RW-1:0]     px_row_c;
    logic              px_in_c;
    logic              in_grid_q;
    logic [7:0]        pixel_color_q;

`ifdef GRID_TREASURE_EN
    logic [1:0]        new_trs_q, new_trs_d;
    logic              ram_trs_we_c;
    logic [1:0]        ram_wtrs_c;
    logic [1:0]        rd_trs;
`endif

    // Handshake qualification and cell addresses
    always_comb begin
        accept_c   = PKT_VALID && pkt_ready_q && !CLEAR;
        in_range_c = (32'(PKT_ROW) < ROWS) && (32'(PKT_COL) < COLS);
        new_idx_c  = cell_idx(new_row_q, new_col_q);
        cur_idx_c  = cell_idx(cur_row_q, cur_col_q);
    end

    // FSM state register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_SWEEP;
            upd_phase_q <= 1'b0;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            upd_phase_q <= upd_phase_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // FSM next state; CLEAR restarts the sweep from any state
    always_comb begin
        state_d     = state_q;
        upd_phase_d = upd_phase_q;
        sweep_idx_d = sweep_idx_q;
        if (CLEAR) begin
            state_d     = ST_SWEEP;
            upd_phase_d = 1'b0;
            sweep_idx_d = '0;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    if (sweep_idx_q == AW'(NCELLS - 1)) begin
                        state_d     = ST_IDLE;
                        sweep_idx_d = '0;
                    end else begin
                        sweep_idx_d = sweep_idx_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept_c && in_range_c) begin
                        state_d     = ST_UPDATE;
                        upd_phase_d = 1'b0;
                    end
                end
                ST_UPDATE: begin
                    if (!upd_phase_q) begin
                        upd_phase_d = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        upd_phase_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end
            endcase
        end
    end

    // FSM outputs: store writes and next values of the tracked position/count
    always_comb begin
        ram_we_c     = 1'b0;
        ram_waddr_c  = '0;
        ram_wstate_c = CELL_UNVISITED;
`ifdef GRID_TREASURE_EN
        ram_trs_we_c = 1'b0;
        ram_wtrs_c   = TRS_NONE;
        new_trs_d    = new_trs_q;
`endif
        new_row_d    = new_row_q;
        new_col_d    = new_col_q;
        cur_valid_d  = cur_valid_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        count_d      = count_q;
        occupied_d   = occupied_q;
        pkt_err_d    = 1'b0;
        pkt_ready_d  = (state_d == ST_IDLE);

        if (CLEAR) begin
            cur_valid_d = 1'b0;
            cur_row_d   = '0;
            cur_col_d   = '0;
            count_d     = '0;
            occupied_d  = '0;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    ram_we_c     = 1'b1;
                    ram_waddr_c  = sweep_idx_q;
                    ram_wstate_c = CELL_UNVISITED;
`ifdef GRID_TREASURE_EN
                    ram_trs_we_c = 1'b1;
                    ram_wtrs_c   = TRS_NONE;
`endif
                end
                ST_IDLE: begin
                    if (accept_c) begin
                        if (in_range_c) begin
                            new_row_d = PKT_ROW;
                            new_col_d = PKT_COL;
`ifdef GRID_TREASURE_EN
                            new_trs_d = PKT_TREASURE;
`endif
                        end else begin
                            pkt_err_d = 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (!upd_phase_q) begin
                        ram_we_c     = cur_valid_q;
                        ram_waddr_c  = cur_idx_c;
                        ram_wstate_c = CELL_VISITED;
                    end else begin
                        ram_we_c     = 1'b1;
                        ram_waddr_c  = new_idx_c;
                        ram_wstate_c = CELL_CURRENT;
`ifdef GRID_TREASURE_EN
                        ram_trs_we_c = (new_trs_q != TRS_NONE);
                        ram_wtrs_c   = new_trs_q;
`endif
                        cur_valid_d  = 1'b1;
                        cur_row_d    = new_row_q;
                        cur_col_d    = new_col_q;
                        if (!occupied_q[new_idx_c]) begin
                            count_d                = count_q + CNT_W'(1);
                            occupied_d[new_idx_c]  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        done_d = (count_d == CNT_W'(NCELLS));
    end

    // Datapath registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            new_row_q   <= '0;
            new_col_q   <= '0;
`ifdef GRID_TREASURE_EN
            new_trs_q   <= '0;
`endif
            cur_valid_q <= 1'b0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            count_q     <= '0;
            occupied_q  <= '0;
            pkt_ready_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            new_row_q   <= new_row_d;
            new_col_q   <= new_col_d;
`ifdef GRID_TREASURE_EN
            new_trs_q   <= new_trs_d;
`endif
            cur_valid_q <= cur_valid_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            count_q     <= count_d;
            occupied_q  <= occupied_d;
            pkt_ready_q <= pkt_ready_d;
            pkt_err_q   <= pkt_err_d;
            done_q      <= done_d;
        end
    end

    // Pixel to cell mapping by threshold comparison
    always_comb begin
        px_col_c = '0;
        px_row_c = '0;
        for (int unsigned k = 1; k < COLS; k++) begin
            if (32'(PIXEL_X) >= k * CELL_PX) px_col_c = CW'(k);
        end
        for (int unsigned k = 1; k < ROWS; k++) begin
            if (32'(PIXEL_Y) >= k * CELL_PX) px_row_c = RW'(k);
        end
        px_in_c = (32'(PIXEL_X) < GRID_W) && (32'(PIXEL_Y) < GRID_H);
    end

    maze_cell_ram #(
        .DEPTH (NCELLS),
        .AW    (AW)
    ) u_ram (
        .clk_i       (CLOCK),
        .wr_en_i     (ram_we_c),
        .wr_addr_i   (ram_waddr_c),
        .wr_state_i  (ram_wstate_c),
`ifdef GRID_TREASURE_EN
        .trs_wr_en_i (ram_trs_we_c),
        .wr_trs_i    (ram_wtrs_c),
        .rd_trs_o    (rd_trs),
`endif
        .rd_addr_i   (cell_idx(px_row_c, px_col_c)),
        .rd_state_o  (rd_state)
    );

`ifdef GRID_TREASURE_EN
    assign rd_trs_c = rd_trs;
`else
    assign rd_trs_c = TRS_NONE;
`endif

    // Stage 1 (store read + in-grid flag), stage 2 (colour)
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_grid_q     <= 1'b0;
            pixel_color_q <= RGB_BLACK;
        end else begin
            in_grid_q     <= px_in_c;
            pixel_color_q <= in_grid_q ? cell_colour(rd_state, rd_trs_c) : RGB_BLACK;
        end
    end

    assign PKT_READY     = pkt_ready_q;
    assign PKT_ERR       = pkt_err_q;
    assign PIXEL_COLOR   = pixel_color_q;
    assign CUR_VALID     = cur_valid_q;
    assign CUR_ROW       = cur_row_q;
    assign CUR_COL       = cur_col_q;
    assign VISITED_COUNT = count_q;
    assign DONE          = done_q;

endmodule
